// File: rtl/mem_bank_xbar_pkg.sv
// mem_bank_xbar_pkg: shared types and helpers for the memory bank crossbar.
//   - default configuration constants and the derived BANK_SEL_W / STRB_W
//   - resp_t: per-master registered response state
//   - dec_t / decode(): byte address -> {bank, word, err}
// decode() is written against generic widths so every crossbar
// configuration can share it; callers truncate the fields they need.
package mem_bank_xbar_pkg;

  localparam int N_MASTERS_DEF = 2;
  localparam int N_BANKS_DEF   = 2;
  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int BANK_AW_DEF   = 14;

  // A bank index always gets at least one bit so N_BANKS=1 still has a field.
  localparam int BANK_SEL_W = (N_BANKS_DEF > 1) ? $clog2(N_BANKS_DEF) : 1;
  localparam int STRB_W     = DATA_W_DEF / 8;

  typedef struct packed {
    logic       valid;
    logic       is_read;
    logic       err;
    logic [7:0] bank;
  } resp_t;

  typedef struct packed {
    logic [7:0]  bank;
    logic [31:0] word;
    logic        err;
  } dec_t;

  // Address layout: [err bits | bank field (sel_bits) | word (bank_aw) | 2'b byte].
  // sel_bits = 0 (single bank) yields an empty bank field and bank = 0.
  function automatic dec_t decode(input logic [63:0] addr, input int bank_aw,
                                  input int sel_bits);
    dec_t        d;
    logic [63:0] sh;
    sh     = addr >> 2;
    d.word = sh[31:0] & ((32'd1 << bank_aw) - 32'd1);
    sh     = addr >> (bank_aw + 2);
    d.bank = sh[7:0] & ((8'd1 << sel_bits) - 8'd1);
    sh     = addr >> (bank_aw + 2 + sel_bits);
    d.err  = |sh;
    return d;
  endfunction

endpackage

// File: rtl/mem_bank_xbar_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req      : request vector
//   ptr      : index with highest priority this cycle
//   gnt      : one-hot grant (all zero when nothing requests)
//   next_ptr : winner+1 mod N after a grant, otherwise ptr unchanged
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  // Scan from ptr upward (wrapping) and take the first requester.
  always_comb begin
    logic found;
    logic hit;
    int   idx;
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx          = (int'(ptr) + i) % N;
      hit          = req[PW'(idx)] & ~found;
      gnt[PW'(idx)] = hit;
      found        = found | hit;
      next_ptr     = hit ? PW'((idx + 1) % N) : next_ptr;
    end
  end

endmodule

// File: rtl/mem_bank_xbar.sv
// mem_bank_xbar: N_MASTERS request ports to N_BANKS single-port SRAM banks.
//   m_req/m_gnt         valid/grant handshake, grant is combinational
//   m_addr/wstrb/wdata  byte address, active-high byte enables (0 = read), data
//   m_rvalid/rdata/err  one-cycle response, the cycle after the grant
//   b_cs/b_web/b_a/b_di bank drive in the grant cycle (b_web active low)
//   b_oe/b_do           bank read enable and data in the response cycle
// Decode-error requests are granted at once and never touch a bank.
module mem_bank_xbar
  import mem_bank_xbar_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int N_BANKS   = N_BANKS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BANK_AW   = BANK_AW_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_MASTERS-1:0]                m_req,
  output logic [N_MASTERS-1:0]                m_gnt,
  input  logic [N_MASTERS-1:0][ADDR_W-1:0]    m_addr,
  input  logic [N_MASTERS-1:0][DATA_W/8-1:0]  m_wstrb,
  input  logic [N_MASTERS-1:0][DATA_W-1:0]    m_wdata,
  output logic [N_MASTERS-1:0]                m_rvalid,
  output logic [N_MASTERS-1:0][DATA_W-1:0]    m_rdata,
  output logic [N_MASTERS-1:0]                m_err,
  output logic [N_BANKS-1:0]                  b_cs,
  output logic [N_BANKS-1:0]                  b_oe,
  output logic [N_BANKS-1:0][DATA_W/8-1:0]    b_web,
  output logic [N_BANKS-1:0][BANK_AW-1:0]     b_a,
  output logic [N_BANKS-1:0][DATA_W-1:0]      b_di,
  input  logic [N_BANKS-1:0][DATA_W-1:0]      b_do
);

  localparam int SEL_W    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int SEL_BITS = $clog2(N_BANKS);
  localparam int SW       = DATA_W / 8;
  localparam int PW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0][SEL_W-1:0]   dec_bank_s;
  logic [N_MASTERS-1:0][BANK_AW-1:0] dec_word_s;
  logic [N_MASTERS-1:0]              dec_err_s;
  logic [N_BANKS-1:0][N_MASTERS-1:0] bank_req_s;
  logic [N_BANKS-1:0][N_MASTERS-1:0] bank_gnt_s;
  logic [N_BANKS-1:0][PW-1:0]        next_ptr_s;
  logic [N_BANKS-1:0][PW-1:0]        rr_ptr_r;
  resp_t [N_MASTERS-1:0]             resp_r;

  // Address decode per master.
  always_comb begin
    dec_t d_v;
    for (int m = 0; m < N_MASTERS; m++) begin
      d_v           = decode(64'(m_addr[m]), BANK_AW, SEL_BITS);
      dec_bank_s[m] = d_v.bank[SEL_W-1:0];
      dec_word_s[m] = d_v.word[BANK_AW-1:0];
      dec_err_s[m]  = d_v.err;
    end
  end

  // Route valid, in-range requests to their bank; reset masks every request
  // so grants and bank selects are forced low while rst is asserted.
  always_comb begin
    for (int k = 0; k < N_BANKS; k++) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        bank_req_s[k][m] = m_req[m] & rst & ~dec_err_s[m] &
                           (dec_bank_s[m] == SEL_W'(k));
      end
    end
  end

  for (genvar k = 0; k < N_BANKS; k++) begin : g_arb
    rr_arbiter #(.N(N_MASTERS)) u_arb (
      .req      (bank_req_s[k]),
      .ptr      (rr_ptr_r[k]),
      .gnt      (bank_gnt_s[k]),
      .next_ptr (next_ptr_s[k])
    );
  end

  // Grants: decode errors bypass arbitration, others OR in the bank winners.
  always_comb begin
    m_gnt = m_req & dec_err_s & {N_MASTERS{rst}};
    for (int k = 0; k < N_BANKS; k++) begin
      m_gnt = m_gnt | bank_gnt_s[k];
    end
  end

  // Bank drive: the grant is one-hot per bank, so AND-OR muxing selects the
  // winner and leaves an idle bank at cs=0, web=all ones, a=0, di=0.
  always_comb begin
    b_cs  = '0;
    b_web = '1;
    b_a   = '0;
    b_di  = '0;
    for (int k = 0; k < N_BANKS; k++) begin
      for (int m = 0; m < N_MASTERS; m++) begin
        b_cs[k]  = b_cs[k] | bank_gnt_s[k][m];
        b_a[k]   = b_a[k] | ({BANK_AW{bank_gnt_s[k][m]}} & dec_word_s[m]);
        b_di[k]  = b_di[k] | ({DATA_W{bank_gnt_s[k][m]}} & m_wdata[m]);
        b_web[k] = b_web[k] & ~({SW{bank_gnt_s[k][m]}} & m_wstrb[m]);
      end
    end
  end

  // Round-robin pointers and the per-master response pipeline stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= '0;
      resp_r   <= '0;
    end else begin
      rr_ptr_r <= next_ptr_s;
      for (int m = 0; m < N_MASTERS; m++) begin
        resp_r[m].valid   <= m_gnt[m];
        resp_r[m].is_read <= m_gnt[m] & ~dec_err_s[m] & ~(|m_wstrb[m]);
        resp_r[m].err     <= m_gnt[m] & dec_err_s[m];
        resp_r[m].bank    <= 8'(dec_bank_s[m]);
      end
    end
  end

  // Response outputs: read data passes straight from the bank that was
  // accessed last cycle; writes and errors return zero.
  always_comb begin
    b_oe = '0;
    for (int m = 0; m < N_MASTERS; m++) begin
      m_rvalid[m] = resp_r[m].valid;
      m_err[m]    = resp_r[m].valid & resp_r[m].err;
      m_rdata[m]  = {DATA_W{resp_r[m].valid & resp_r[m].is_read}} &
                    b_do[resp_r[m].bank[SEL_W-1:0]];
      for (int k = 0; k < N_BANKS; k++) begin
        b_oe[k] = b_oe[k] | (resp_r[m].valid & resp_r[m].is_read &
                             (resp_r[m].bank[SEL_W-1:0] == SEL_W'(k)));
      end
    end
  end

endmodule
